// File: rtl/time_ctrl.sv
// time_ctrl: seconds prescaler, button conditioning and run/set sequencing for
// the BCD time-of-day counter. Every output is a flop so the counter clocks stay glitch-free.

module time_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // level only follows sync after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_ctrl #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int BLINK_DIV       = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] tm_clk,
  output logic       tm_mode,
  output logic       tick_1hz,
  output logic [1:0] blink_sel,
  output logic       blink_on
);
  localparam int NUM_BTN  = 2;
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;

  typedef struct packed {
    logic [2:0] tm_clk;
    logic       tm_mode;
    logic       tick_1hz;
    logic [1:0] blink_sel;
    logic       blink_on;
  } out_t;

  localparam out_t OUT_RST = '{tm_clk: 3'b000, tm_mode: 1'b1, tick_1hz: 1'b0,
                               blink_sel: 2'b00, blink_on: 1'b1};

  state_t               state, state_nx;
  out_t                 out_q, out_nx;
  logic [PW-1:0]        presc;
  logic [BW-1:0]        bcnt;
  logic [RW-1:0]        rpt_cnt;
  logic                 rpt_first;
  logic [NUM_BTN-1:0]   btn_raw, btn_lvl, btn_lvl_q, btn_press;
  logic                 mode_evt, inc_evt, set_st, wrap, rpt_fire, inc_fire, blink_wrap, entry;

  assign btn_raw = {btn_inc, btn_mode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    time_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_lvl[i])
    );
  end

  assign btn_press = btn_lvl & ~btn_lvl_q;
  assign mode_evt  = btn_press[BTN_MODE];
  assign inc_evt   = btn_press[BTN_INC];

  always_comb begin
    state_nx = state;
    if (mode_evt) begin
      case (state)
        RUN:      state_nx = SET_HOUR;
        SET_HOUR: state_nx = SET_MIN;
        default:  state_nx = RUN;
      endcase
    end

    set_st     = (state != RUN);
    wrap       = (state == RUN) && (presc == PW'(TICK_DIV - 1));
    rpt_fire   = set_st && btn_lvl[BTN_INC] &&
                 (rpt_first ? (rpt_cnt == RW'(REPEAT_DELAY)) : (rpt_cnt == RW'(REPEAT_PERIOD)));
    // a mode press in the same cycle swallows any increment
    inc_fire   = set_st && !mode_evt && (inc_evt || rpt_fire);
    entry      = (state_nx != state);
    blink_wrap = (bcnt == BW'(BLINK_DIV - 1));

    out_nx           = OUT_RST;
    out_nx.tm_clk    = {inc_fire && (state == SET_HOUR), inc_fire && (state == SET_MIN), wrap};
    out_nx.tick_1hz  = wrap;
    out_nx.tm_mode   = (state_nx == RUN);
    out_nx.blink_sel = (state_nx == SET_HOUR) ? 2'b10 : (state_nx == SET_MIN) ? 2'b01 : 2'b00;
    if (entry || state_nx == RUN) out_nx.blink_on = 1'b1;
    else if (blink_wrap)          out_nx.blink_on = ~out_q.blink_on;
    else                          out_nx.blink_on = out_q.blink_on;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q     <= OUT_RST;
      presc     <= '0;
      bcnt      <= '0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      btn_lvl_q <= '0;
    end else begin
      out_q     <= out_nx;
      btn_lvl_q <= btn_lvl;

      // prescaler only runs while staying in RUN; any entry restarts it at 0
      if (state == RUN && state_nx == RUN) presc <= wrap ? '0 : presc + 1'b1;
      else                                 presc <= '0;

      if (entry || state_nx == RUN) bcnt <= '0;
      else if (blink_wrap)          bcnt <= '0;
      else                          bcnt <= bcnt + 1'b1;

      if (!btn_lvl[BTN_INC] || !set_st || mode_evt) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (inc_evt || rpt_fire) begin
        rpt_cnt   <= RW'(1);
        rpt_first <= inc_evt;
      end else if (rpt_cnt != '0) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign tm_clk    = out_q.tm_clk;
  assign tm_mode   = out_q.tm_mode;
  assign tick_1hz  = out_q.tick_1hz;
  assign blink_sel = out_q.blink_sel;
  assign blink_on  = out_q.blink_on;
endmodule
